// File: rtl/fifo_pkg.sv
// Shared sizing helpers and the output-buffer occupancy type for the DPRAM FIFO controller.
// Combinational helpers only; no latency or backpressure of their own.
package fifo_pkg;

  // Output buffer holds at most two words, so occupancy is 0..2.
  typedef logic [1:0] fifo_occ_t;

  localparam fifo_occ_t BUF_FULL = 2'd2;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 3);
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry in-order skid queue between the RAM read port and the stream output; head is registered.
// One-cycle write-to-head latency; accepts write and read in the same cycle; caller keeps it from overflowing.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head,
  output fifo_occ_t             cnt
);

  logic [DATA_WIDTH-1:0] tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10: begin
          if (cnt == 2'd0) head <= wr_data;
          else             tail <= wr_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          // With one entry left the head keeps its value so an idle output holds the last word.
          if (cnt == BUF_FULL) head <= tail;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == BUF_FULL) begin
            head <= tail;
            tail <= wr_data;
          end else begin
            head <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_ctrl_dpram.sv
// FIFO controller for an external registered-output DPRAM (A write, B read); 3-cycle fall-through, 1 word/cycle.
// s_ready drops when the RAM holds DEPTH words; m_valid/m_data hold steady while the consumer stalls.
module fifo_ctrl_dpram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
);

  localparam int PTR_WIDTH = ptr_width(DEPTH);

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] ram_occ;
  logic                 inflight;
  fifo_occ_t            buf_cnt;
  logic [2:0]           buf_pending;
  logic                 push;
  logic                 pop;
  logic                 fetch;

  assign ram_occ = wr_ptr - rd_ptr;

  // s_ready looks only at registered pointers so no input reaches it combinationally.
  assign s_ready = (ram_occ != PTR_WIDTH'(DEPTH)) && !rst;
  assign push    = s_valid && s_ready;

  assign m_valid = (buf_cnt != 2'd0);
  assign pop     = m_valid && m_ready;

  // Reserve a buffer slot for every read in flight; a pop this cycle frees one early.
  assign buf_pending = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
  assign fetch       = (ram_occ != '0) && (buf_pending < 3'd2);

  assign ram_we_a   = push;
  assign ram_addr_a = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_din_a  = s_data;
  assign ram_addr_b = rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (fetch) rd_ptr <= rd_ptr + 1'b1;
      inflight <= fetch;
    end
  end

  fifo_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (ram_dout_b),
    .rd_en   (pop),
    .head    (m_data),
    .cnt     (buf_cnt)
  );

  assign count = CNT_WIDTH'(ram_occ) + CNT_WIDTH'(buf_cnt) + CNT_WIDTH'(inflight);

endmodule

// File: tb/tb_fifo_ctrl_dpram.sv
// Bench for fifo_ctrl_dpram with a behavioural registered-output DPRAM beside it.
// Directed sequences plus a seeded random backpressure run against a queue scoreboard.
module tb_fifo_ctrl_dpram;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int CW = 5;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] count;
  logic          ram_we_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_din_a;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_dout_b;

  logic [DW-1:0] ram [DEPTH];

  int n_cmp = 0;
  int n_err = 0;
  int model_cnt = 0;
  logic [DW-1:0] sb [$];

  fifo_ctrl_dpram dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .count      (count),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_addr_b (ram_addr_b),
    .ram_dout_b (ram_dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) ram[ram_addr_a] <= ram_din_a;
    ram_dout_b <= ram[ram_addr_b];
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given inputs; scoreboard tracks data order, model_cnt the words held.
  task automatic do_cycle(input logic sv, input logic [DW-1:0] sd, input logic mr);
    logic pushed;
    logic popped;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    #1;
    pushed = sv && s_ready;
    popped = m_valid && mr;
    if (popped) begin
      if (sb.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
      else check("pop_data", m_data, sb.pop_front());
    end
    if (pushed) sb.push_back(sd);
    tick();
    model_cnt = model_cnt + int'(pushed) - int'(popped);
    check("count", 32'(count), 32'(model_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int budget;
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    m_ready = 1'b1;
    #22;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_we", 32'(ram_we_a), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single word: pushed at edge k, visible after edge k+2, popped at k+3.
    s_valid = 1'b1;
    s_data  = 32'hA5A5_0001;
    m_ready = 1'b1;
    #1;
    check("sw_we", 32'(ram_we_a), 32'd1);
    check("sw_addr", 32'(ram_addr_a), 32'd0);
    check("sw_din", ram_din_a, 32'hA5A5_0001);
    tick();
    s_valid = 1'b0;
    check("sw_cnt_k", 32'(count), 32'd1);
    check("sw_mv_k", 32'(m_valid), 32'd0);
    tick();
    check("sw_mv_k1", 32'(m_valid), 32'd0);
    tick();
    check("sw_mv_k2", 32'(m_valid), 32'd1);
    check("sw_data", m_data, 32'hA5A5_0001);
    check("sw_cnt_k2", 32'(count), 32'd1);
    tick();
    check("sw_cnt_k3", 32'(count), 32'd0);
    check("sw_mv_k3", 32'(m_valid), 32'd0);
    check("sw_hold", m_data, 32'hA5A5_0001);

    // Fill with the consumer stalled: RAM takes DEPTH, buffer takes 2 more.
    acc = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(i);
      if (s_ready) acc++;
      if (i >= 18) begin
        #1;
        check("full_we", 32'(ram_we_a), 32'd0);
      end
      tick();
    end
    s_valid = 1'b0;
    check("fill_accepted", 32'(acc), 32'd18);
    check("fill_count", 32'(count), 32'd18);
    check("fill_s_ready", 32'(s_ready), 32'd0);
    check("fill_m_valid", 32'(m_valid), 32'd1);
    check("fill_head", m_data, 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      check("drain_valid", 32'(m_valid), 32'd1);
      check("drain_data", m_data, 32'(i));
      tick();
    end
    check("drain_empty", 32'(m_valid), 32'd0);
    check("drain_count", 32'(count), 32'd0);
    check("drain_s_ready", 32'(s_ready), 32'd1);

    // Streaming: count settles at 3 and output never gaps once the pipe is full.
    model_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      do_cycle(1'b1, 32'h0000_0100 + 32'(i), 1'b1);
      if (i >= 2) begin
        check("stream_count", 32'(count), 32'd3);
        check("stream_valid", 32'(m_valid), 32'd1);
      end
    end
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      do_cycle(1'b0, 32'd0, 1'b1);
      budget--;
    end
    check("stream_drained", 32'(sb.size()), 32'd0);

    // Random valid/ready exercising pointer wrap under backpressure.
    for (int i = 0; i < 2000; i++) begin
      do_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    budget = 40;
    while (sb.size() > 0 && budget > 0) begin
      do_cycle(1'b0, 32'd0, 1'b1);
      budget--;
    end
    check("rand_drained", 32'(sb.size()), 32'd0);
    check("rand_count", 32'(count), 32'd0);

    // Reset with 7 held and a RAM read in flight.
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 32'h0000_0700 + 32'(i), 1'b0);
    do_cycle(1'b1, 32'h0000_0707, 1'b1);
    check("pre_rst_count", 32'(count), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check("mid_rst_m_data", m_data, 32'd0);
    sb.delete();
    model_cnt = 0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_cycle(1'b1, 32'h0000_1234, 1'b1);
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      do_cycle(1'b0, 32'd0, 1'b1);
      budget--;
    end
    check("post_rst_drained", 32'(sb.size()), 32'd0);
    check("post_rst_m_valid", 32'(m_valid), 32'd0);
    check("post_rst_last", m_data, 32'h0000_1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_dpram.md
# fifo_ctrl_dpram

Single-clock FIFO controller that drives a registered-output, single-clock dual-port RAM: port A as write-only, port B as read-only. It turns valid/ready streams on both sides into RAM writes and reads, and hides the RAM's 1-cycle read latency behind a 2-entry output buffer so the stream sustains 1 word/cycle. It sits directly upstream of the RAM and owns all pointer, full and empty logic; the RAM stays a pure storage array.

## Interface
- DATA_WIDTH, 32, word width
- DEPTH, 16, RAM entries; power of 2, ≥ 4
- ADDR_WIDTH, $clog2(DEPTH), RAM address width
- CNT_WIDTH, $clog2(DEPTH+3), width of `count`
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  write-side data valid
- s_ready  out  1  write side can accept
- s_data  in  DATA_WIDTH  write data
- m_valid  out  1  read-side data valid
- m_ready  in  1  read-side consumer accepts
- m_data  out  DATA_WIDTH  read data (registered)
- count  out  CNT_WIDTH  total words held (RAM + in flight + buffer), 0..DEPTH+2
- ram_we_a  out  1  RAM port A write enable
- ram_addr_a  out  ADDR_WIDTH  RAM port A address
- ram_din_a  out  DATA_WIDTH  RAM port A write data
- ram_addr_b  out  ADDR_WIDTH  RAM port B address; port B write enable is tied 0 at the RAM
- ram_dout_b  in  DATA_WIDTH  RAM port B registered read data, valid 1 cycle after the address

## Operation
- Pointers `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits and wrap naturally. `ram_occ = wr_ptr - rd_ptr` (modulo arithmetic).
- Push: `push = s_valid & s_ready`, with `s_ready = (ram_occ != DEPTH) & !rst`.
  - `ram_we_a = push`, `ram_addr_a = wr_ptr[ADDR_WIDTH-1:0]`, `ram_din_a = s_data`. All are combinational.
  - `wr_ptr` increments on push.
- Pop: `pop = m_valid & m_ready`, where `m_valid = (buf_cnt != 0)`.
- Fetch: `fetch = (ram_occ != 0) & (buf_cnt + inflight - pop < 2)`.
  - `ram_addr_b = rd_ptr[ADDR_WIDTH-1:0]`.
  - On fetch: `rd_ptr` increments and `inflight` is set to 1 for the next cycle; otherwise `inflight` is 0.
- Capture: while `inflight` = 1, `ram_dout_b` is pushed into the output buffer that cycle.
- Output buffer: a 2-entry in-order queue. The head drives `m_data`. Invariant: `buf_cnt + inflight ≤ 2`.
- Simultaneous push and fetch on the same address cannot occur. Fetch only reads entries counted in `ram_occ` from registered pointers, so those entries were written at an earlier edge.
- Simultaneous push and pop: both take effect; `count` is unchanged.
- Full: `ram_occ == DEPTH` → `s_ready` = 0. The total held may reach DEPTH+2.
- Empty: `buf_cnt == 0` → `m_valid` = 0 and `m_data` holds its last value.
- Reset, at any time including mid-transfer:
  - pointers, `buf_cnt` and `inflight` clear to 0; any in-flight read data is discarded;
  - `m_valid` = 0, `m_data` = 0, `count` = 0, `ram_we_a` = 0, `s_ready` = 0 while `rst` is high.
  - RAM contents are not cleared (not required).

## Timing
- Fall-through latency, empty FIFO: push accepted at edge k → RAM write at k → fetch issued in cycle k+1 → `ram_dout_b` valid at k+2 → `m_valid` = 1 after edge k+2 (3 cycles).
- Throughput: 1 push and 1 pop per cycle, sustained indefinitely, with `m_ready` held high.
- `m_data` and `m_valid` are stable while `m_valid & !m_ready`. No combinational path from `m_ready` to `m_data`.
- `s_ready` depends only on registered state and `rst`. It has no combinational path from `s_valid` or `m_ready`.
- `count` updates at the edge that applies the push and/or pop.

## Structure
- Package `fifo_pkg` holds the pointer-width and count-width helper functions and a `fifo_occ_t` typedef.
- Sub-module `fifo_out_buf` implements the 2-entry output queue.
  - Inputs: `wr_en`, `wr_data`, `rd_en`.
  - Outputs: `head`, `cnt`.
- Top level contains the pointers, fetch logic and `inflight` flag, and connects to an external RAM instance. The testbench instantiates the RAM alongside.

## Test plan
- Single word: after reset push 0xA5A5_0001 at edge k with `m_ready` = 1 → `m_valid` = 1 in cycle k+3 with `m_data` = 0xA5A5_0001; `count` goes 1 then 0.
- Fill with `m_ready` = 0, DEPTH = 16: push 0..19 → `s_ready` drops after 18 accepted words; `count` = 18.
  - Then `m_ready` = 1 → words 0..17 appear in order, one per cycle, with no gaps.
- Streaming: `s_valid` = `m_ready` = 1 for 100 cycles with an incrementing pattern → after the 3-cycle fill, one output per cycle, in order, with `count` constant at steady state.
- Wrap and backpressure: random `s_valid` and `m_ready` (50%) for 2000 cycles → scoreboard exact order with no loss or duplication, and `count` equal to the model on every cycle.
- Reset mid-operation: assert `rst` asynchronously with `count` = 7 and a fetch in flight → immediately `m_valid` = 0 and `count` = 0.
  - After release, push 0x1234 → it is the first word out, with no stale data.
